// File: rtl/mmu_pkg.sv
// Shared types and constants for the 68k-style MMU/TLB: FSM state encoding,
// supervisor region boundaries and fixed-map page bases.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_e;

  // Exclusive upper bounds of each supervisor region (virtual page, 12 bits)
  localparam logic [11:0] REG_LOW_END  = 12'h400;
  localparam logic [11:0] REG_MID_END  = 12'h800;
  localparam logic [11:0] REG_IO0_END  = 12'h900;
  localparam logic [11:0] REG_IO1_END  = 12'h980;
  localparam logic [11:0] REG_IO2_END  = 12'hA00;
  localparam logic [11:0] REG_WIN1_END = 12'hB00;
  localparam logic [11:0] REG_WIN2_END = 12'hC00;

  localparam logic [15:0] BASE_LOW  = 16'h8000;
  localparam logic [15:0] BASE_MID  = 16'h4000;
  localparam logic [15:0] BASE_IO0  = 16'h0300;
  localparam logic [15:0] BASE_IO1  = 16'h0100;
  localparam logic [15:0] BASE_IO2  = 16'h0200;
  localparam logic [15:0] BASE_HIGH = 16'h3000;

endpackage

// File: rtl/mmu_super_map.sv
// Combinational supervisor fixed map: virtual page -> physical page, with two
// software-selectable 256-page windows.
module mmu_super_map
  import mmu_pkg::*;
(
  input  logic [11:0] addr_in,
  input  logic [7:0]  map_1,
  input  logic [7:0]  map_2,
  output logic [15:0] page
);

  always_comb begin
    page = '0;
    if (addr_in < REG_LOW_END)
      page = BASE_LOW | {4'h0, addr_in};
    else if (addr_in < REG_MID_END)
      page = BASE_MID + {4'h0, addr_in - REG_LOW_END};
    else if (addr_in < REG_IO0_END)
      page = BASE_IO0 | {8'h00, addr_in[7:0]};
    else if (addr_in < REG_IO1_END)
      page = BASE_IO1 | {9'h000, addr_in[6:0]};
    else if (addr_in < REG_IO2_END)
      page = BASE_IO2 | {9'h000, addr_in[6:0]};
    else if (addr_in < REG_WIN1_END)
      page = {map_1, addr_in[7:0]};
    else if (addr_in < REG_WIN2_END)
      page = {map_2, addr_in[7:0]};
    else
      page = BASE_HIGH | {4'h0, addr_in};
  end

endmodule

// File: rtl/mmu_tlb.sv
// Fully-associative TLB with supervisor fixed map and page-table walk on user miss.
// Optional hit/miss statistics counters are built when MMU_TLB_STATS_EN is defined.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned TASK_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [11:0]         addr_in,
  input  logic [2:0]          fc,
  input  logic [TASK_W-1:0]   user_map,
  input  logic [7:0]          supervisor_map_1,
  input  logic [7:0]          supervisor_map_2,
  input  logic                flush,
  output logic                table_rd,
  output logic [TASK_W+11:0]  table_addr,
  input  logic [15:0]         table_data,
  input  logic                table_ack,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [15:0]         addr_out
`ifdef MMU_TLB_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  localparam int unsigned TAG_W = TASK_W + 12;
  localparam int unsigned PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  state_e state_q, state_d;

  logic [TLB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [TLB_ENTRIES];
  logic [15:0]            page_q [TLB_ENTRIES];
  logic [PTR_W-1:0]       ptr_q;
  logic [TAG_W-1:0]       walk_tag_q;
  logic                   kill_q;
  logic [15:0]            addr_out_q;

  logic [TAG_W-1:0] lookup_tag;
  logic [15:0]      super_page;
  logic [15:0]      hit_page;
  logic             hit_any;
  logic             hit;
  logic             is_super;
  logic             accept;
  logic             fill_en;
  logic             unused_fc;

  assign lookup_tag = {user_map, addr_in};
  assign is_super   = fc[2];
  assign unused_fc  = ^fc[1:0];
  assign accept     = req_valid && req_ready;
  assign table_addr = walk_tag_q;
  assign addr_out   = addr_out_q;

  mmu_super_map u_super_map (
    .addr_in (addr_in),
    .map_1   (supervisor_map_1),
    .map_2   (supervisor_map_2),
    .page    (super_page)
  );

  always_comb begin
    hit_any  = 1'b0;
    hit_page = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
        hit_any  = 1'b1;
        hit_page = hit_page | page_q[i];
      end
    end
    // A flush in the accept cycle wins over any stale match
    hit = hit_any && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    table_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (is_super || hit) ? RESP : WALK;
      end
      WALK: begin
        table_rd = 1'b1;
        if (table_ack) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_en = (state_q == WALK) && table_ack && !kill_q && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      ptr_q      <= '0;
      walk_tag_q <= '0;
      kill_q     <= 1'b0;
      addr_out_q <= '0;
    end else begin
      if (flush)        valid_q        <= '0;
      else if (fill_en) valid_q[ptr_q] <= 1'b1;

      if (fill_en) begin
        if (ptr_q == PTR_W'(TLB_ENTRIES - 1)) ptr_q <= '0;
        else                                  ptr_q <= ptr_q + 1'b1;
      end

      if (accept && !is_super && !hit) begin
        walk_tag_q <= lookup_tag;
        kill_q     <= 1'b0;
      end else if ((state_q == WALK) && flush) begin
        kill_q <= 1'b1;
      end

      if (accept) addr_out_q <= is_super ? super_page : hit_page;
      else if ((state_q == WALK) && table_ack) addr_out_q <= table_data;
    end
  end

  // Entry contents need no reset: valid_q gates every use
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[ptr_q]  <= walk_tag_q;
      page_q[ptr_q] <= table_data;
    end
  end

`ifdef MMU_TLB_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept && !is_super) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
